// File: rtl/dmem_store_buffer.sv
// -----------------------------------------------------------------------------
// dmem_store_buffer
//   Posted-store buffer between the MEM stage and a single-port, byte-addressed
//   data memory. Stores (sb/sh/sw) are queued in a DEPTH-entry FIFO and drained
//   in order, one per cycle, whenever the memory port is not taken by a load.
//   A load that overlaps any pending store is stalled; the stall never blocks
//   the drain, so the overlapping entry always leaves and the load proceeds.
//
//   Optional feature macro: STORE_FWD_EN
//     defined   : a load whose youngest overlapping entry has the same address
//                 and size is served from the buffer (fwd_valid/fwd_data) and
//                 is not stalled; any other overlap still stalls.
//     undefined : fwd_valid = 0 and fwd_data = 0; every overlap stalls.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   st_valid/st_funct3/st_addr/st_data -> st_ready   store request handshake
//   ld_valid/ld_funct3/ld_addr -> ld_stall           load in MEM stage
//   drain_req -> fence_busy                          fence: block stores until empty
//   empty, count                                     buffer occupancy
//   mem_we/mem_funct3/mem_addr/mem_wdata             memory port drive
//   fwd_valid/fwd_data                               forwarded load data
// -----------------------------------------------------------------------------
module dmem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   st_valid,
  input  logic [2:0]             st_funct3,
  input  logic [ADDR_W-1:0]      st_addr,
  input  logic [DATA_W-1:0]      st_data,
  output logic                   st_ready,
  input  logic                   ld_valid,
  input  logic [2:0]             ld_funct3,
  input  logic [ADDR_W-1:0]      ld_addr,
  output logic                   ld_stall,
  input  logic                   drain_req,
  output logic                   fence_busy,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   mem_we,
  output logic [2:0]             mem_funct3,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   fwd_valid,
  output logic [DATA_W-1:0]      fwd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RNG_W = ADDR_W + 2;   // room for addr+3 without wrap-around

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FENCE  = 2'd2
  } sb_state_e;

  sb_state_e         state_r, state_next_s;

  logic              ent_valid_r  [DEPTH];
  logic [2:0]        ent_funct3_r [DEPTH];
  logic [ADDR_W-1:0] ent_addr_r   [DEPTH];
  logic [DATA_W-1:0] ent_data_r   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  count_r, count_next_s;

  logic              full_s, empty_s, st_size_ok_s, push_s, pop_s;
  logic              stall_s, load_owns_s;
  logic [DEPTH-1:0]  hit_s;

  // Last byte covered by an access: addr + size - 1, widened so it never wraps.
  function automatic logic [RNG_W-1:0] range_last(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0]        f3);
    logic [RNG_W-1:0] span;
    case (f3[1:0])
      2'b00:   span = {RNG_W{1'b0}};
      2'b01:   span = {{(RNG_W-2){1'b0}}, 2'd1};
      default: span = {{(RNG_W-2){1'b0}}, 2'd3};
    endcase
    return {2'b00, a} + span;
  endfunction

  function automatic logic ranges_overlap(input logic [ADDR_W-1:0] a,
                                          input logic [2:0]        af3,
                                          input logic [ADDR_W-1:0] b,
                                          input logic [2:0]        bf3);
    return ({2'b00, a} <= range_last(b, bf3)) && ({2'b00, b} <= range_last(a, af3));
  endfunction

  assign full_s       = (count_r == CNT_W'(DEPTH));
  assign empty_s      = (count_r == {CNT_W{1'b0}});
  assign st_size_ok_s = (st_funct3 == 3'b000) || (st_funct3 == 3'b001) || (st_funct3 == 3'b010);
  // Readiness deliberately ignores a same-cycle pop: a full buffer is never ready.
  assign st_ready     = !full_s && (state_r != ST_FENCE);
  // Unsupported sizes complete the handshake but are dropped here.
  assign push_s       = st_valid && st_ready && st_size_ok_s;
  assign empty        = empty_s;
  assign count        = count_r;
  assign fence_busy   = drain_req && !empty_s;

  // Per-entry overlap of the current load against every pending store.
  always_comb begin
    hit_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      hit_s[i] = ld_valid && ent_valid_r[i] &&
                 ranges_overlap(ent_addr_r[i], ent_funct3_r[i], ld_addr, ld_funct3);
    end
  end

`ifdef STORE_FWD_EN
  logic              fwd_hit_s;
  logic [DATA_W-1:0] fwd_raw_s;

  function automatic logic [PTR_W-1:0] age_index(input logic [PTR_W-1:0] base, input int k);
    return base + PTR_W'(k);
  endfunction

  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] d,
                                                    input logic [2:0]        f3);
    case (f3)
      3'b000:  return {{(DATA_W-8){d[7]}}, d[7:0]};
      3'b001:  return {{(DATA_W-16){d[15]}}, d[15:0]};
      3'b100:  return {{(DATA_W-8){1'b0}}, d[7:0]};
      3'b101:  return {{(DATA_W-16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Walk oldest to youngest so the last overlap seen decides forwarding.
  always_comb begin
    fwd_hit_s = 1'b0;
    fwd_raw_s = {DATA_W{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      if (hit_s[age_index(rd_ptr_r, k)]) begin
        fwd_hit_s = (ent_addr_r[age_index(rd_ptr_r, k)] == ld_addr) &&
                    (ent_funct3_r[age_index(rd_ptr_r, k)][1:0] == ld_funct3[1:0]);
        fwd_raw_s = ent_data_r[age_index(rd_ptr_r, k)];
      end else begin
        fwd_hit_s = fwd_hit_s;
        fwd_raw_s = fwd_raw_s;
      end
    end
  end

  assign stall_s   = (|hit_s) && !fwd_hit_s;
  assign fwd_valid = fwd_hit_s;
  assign fwd_data  = fwd_hit_s ? extend_load(fwd_raw_s, ld_funct3) : {DATA_W{1'b0}};
`else
  assign stall_s   = |hit_s;
  assign fwd_valid = 1'b0;
  assign fwd_data  = {DATA_W{1'b0}};
`endif

  assign ld_stall    = stall_s;
  assign load_owns_s = ld_valid && !stall_s;

  // Memory port mux: an unstalled load wins, otherwise the FIFO head drains.
  always_comb begin
    mem_we     = 1'b0;
    mem_funct3 = ld_funct3;
    mem_addr   = ld_addr;
    mem_wdata  = ent_data_r[rd_ptr_r];
    pop_s      = 1'b0;
    if (load_owns_s) begin
      mem_we = 1'b0;
    end else if (!empty_s) begin
      mem_we     = 1'b1;
      mem_funct3 = ent_funct3_r[rd_ptr_r];
      mem_addr   = ent_addr_r[rd_ptr_r];
      pop_s      = 1'b1;
    end else begin
      mem_we = 1'b0;
    end
  end

  assign count_next_s = count_r + {{(CNT_W-1){1'b0}}, push_s} - {{(CNT_W-1){1'b0}}, pop_s};

  // Next-state logic; reaching zero occupancy always returns to IDLE.
  always_comb begin
    state_next_s = state_r;
    if (count_next_s == {CNT_W{1'b0}}) begin
      state_next_s = ST_IDLE;
    end else if (drain_req && !empty_s) begin
      state_next_s = ST_FENCE;
    end else begin
      case (state_r)
        ST_IDLE:   state_next_s = ST_ACTIVE;
        ST_ACTIVE: state_next_s = ST_ACTIVE;
        ST_FENCE:  state_next_s = ST_FENCE;
        default:   state_next_s = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid_r[i]  <= 1'b0;
        ent_funct3_r[i] <= 3'b000;
        ent_addr_r[i]   <= {ADDR_W{1'b0}};
        ent_data_r[i]   <= {DATA_W{1'b0}};
      end
    end else begin
      if (pop_s) begin
        ent_valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r              <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (push_s) begin
        ent_valid_r[wr_ptr_r]  <= 1'b1;
        ent_funct3_r[wr_ptr_r] <= st_funct3;
        ent_addr_r[wr_ptr_r]   <= st_addr;
        ent_data_r[wr_ptr_r]   <= st_data;
        wr_ptr_r               <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      count_r <= count_next_s;
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_dmem_store_buffer
//   Directed scenarios followed by random traffic. Expected behaviour comes from
//   a queue-based model of pending stores, a fence flag and a byte memory that
//   the DUT's write port updates. Honours STORE_FWD_EN like the design.
// -----------------------------------------------------------------------------
module tb_dmem_store_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              st_valid = 1'b0;
  logic [2:0]        st_funct3 = 3'b000;
  logic [ADDR_W-1:0] st_addr = '0;
  logic [DATA_W-1:0] st_data = '0;
  logic              st_ready;
  logic              ld_valid = 1'b0;
  logic [2:0]        ld_funct3 = 3'b000;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic              ld_stall;
  logic              drain_req = 1'b0;
  logic              fence_busy, empty;
  logic [$clog2(DEPTH):0] count;
  logic              mem_we;
  logic [2:0]        mem_funct3;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              fwd_valid;
  logic [DATA_W-1:0] fwd_data;

  always #5 clk = ~clk;

  dmem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_funct3(st_funct3), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_funct3(ld_funct3), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .drain_req(drain_req), .fence_busy(fence_busy), .empty(empty), .count(count),
    .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .fwd_valid(fwd_valid), .fwd_data(fwd_data)
  );

  typedef struct {
    int          addr;
    int          sz;
    logic [2:0]  f3;
    logic [31:0] data;
  } st_t;

  st_t  q[$];
  bit   fence_m = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  logic [7:0] mem_bytes [1024];

  function automatic int sz_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ext_load(input logic [31:0] d, input logic [2:0] f3);
    case (f3)
      3'b000:  return 32'($signed(d[7:0]));
      3'b001:  return 32'($signed(d[15:0]));
      3'b100:  return {24'h0, d[7:0]};
      3'b101:  return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Little-endian read of the bench memory, extended like a load would be.
  function automatic logic [31:0] mem_read(input int a, input logic [2:0] f3);
    logic [31:0] w;
    w = {mem_bytes[(a + 3) & 1023], mem_bytes[(a + 2) & 1023],
         mem_bytes[(a + 1) & 1023], mem_bytes[a & 1023]};
    return ext_load(w, f3);
  endfunction

  // Bench memory written through the DUT's port.
  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < sz_of(mem_funct3); i++)
        mem_bytes[(int'(mem_addr) + i) & 1023] <= mem_wdata[8*i +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_st(input bit v, input logic [2:0] f3, input int a, input logic [31:0] d);
    st_valid = v; st_funct3 = f3; st_addr = ADDR_W'(a); st_data = d;
  endtask

  task automatic set_ld(input bit v, input logic [2:0] f3, input int a);
    ld_valid = v; ld_funct3 = f3; ld_addr = ADDR_W'(a);
  endtask

  // One clock: check outputs against the model at negedge, advance the model at posedge.
  task automatic cycle();
    int sz, lsz, yi;
    bit ov, fwd, stall, owns, we, ready, push, drn;
    logic [31:0] fexp;
    st_t e;
    @(negedge clk);
    sz    = q.size();
    ready = (sz < DEPTH) && !fence_m;
    lsz   = sz_of(ld_funct3);
    ov = 1'b0; yi = 0;
    for (int i = 0; i < sz; i++) begin
      if (q[i].addr <= int'(ld_addr) + lsz - 1 && int'(ld_addr) <= q[i].addr + q[i].sz - 1) begin
        ov = 1'b1; yi = i;
      end
    end
    fwd = 1'b0; fexp = 32'h0;
`ifdef STORE_FWD_EN
    if (ld_valid && ov && q[yi].addr == int'(ld_addr) && q[yi].sz == lsz) begin
      fwd = 1'b1; fexp = ext_load(q[yi].data, ld_funct3);
    end
`endif
    stall = ld_valid && ov && !fwd;
    owns  = ld_valid && !stall;
    we    = !owns && (sz > 0);
    check("st_ready", st_ready, ready);
    check("ld_stall", ld_stall, stall);
    check("mem_we", mem_we, we);
    check("empty", empty, sz == 0);
    check("count", count, sz);
    check("fence_busy", fence_busy, drain_req && (sz > 0));
    check("fwd_valid", fwd_valid, fwd);
    if (fwd) check("fwd_data", fwd_data, fexp);
`ifndef STORE_FWD_EN
    check("fwd_data_zero", fwd_data, 32'h0);
`endif
    if (we) begin
      check("wr_addr", mem_addr, q[0].addr);
      check("wr_funct3", mem_funct3, q[0].f3);
      check("wr_data", mem_wdata, q[0].data);
    end
    if (owns) begin
      check("ld_addr_port", mem_addr, ld_addr);
      check("ld_funct3_port", mem_funct3, ld_funct3);
    end
    push = st_valid && ready && (st_funct3 inside {3'b000, 3'b001, 3'b010});
    drn  = drain_req;
    e.addr = int'(st_addr); e.sz = sz_of(st_funct3); e.f3 = st_funct3; e.data = st_data;
    @(posedge clk);
    if (we) void'(q.pop_front());
    if (push) q.push_back(e);
    if (q.size() == 0) fence_m = 1'b0;
    else if (drn && sz > 0) fence_m = 1'b1;
    #1;
  endtask

  initial begin
    int r, n;
    logic [2:0] lf3 [5];
    lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 1024; i++) mem_bytes[i] = 8'h00;

    // Reset values.
    #12;
    check("rst_st_ready", st_ready, 1'b1);
    check("rst_empty", empty, 1'b1);
    check("rst_count", count, 0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_ld_stall", ld_stall, 1'b0);
    check("rst_fence_busy", fence_busy, 1'b0);
    check("rst_fwd_valid", fwd_valid, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: reset in the middle of a fill discards pending stores.
    set_ld(1'b1, 3'b010, 12'h300);
    for (int i = 0; i < 3; i++) begin
      set_st(1'b1, 3'b010, 12'h100 + 4 * i, $urandom);
      cycle();
    end
    rst_n = 1'b0; q.delete(); fence_m = 1'b0;
    set_st(1'b0, 3'b000, 0, 32'h0); set_ld(1'b0, 3'b000, 0);
    #2;
    check("t1_count", count, 0);
    check("t1_empty", empty, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cycle();

    // 2: load overlapping a pending word stalls one cycle while it drains.
    set_st(1'b1, 3'b010, 12'h010, 32'hDEADBEEF);
    cycle();
    set_st(1'b0, 3'b000, 0, 32'h0); set_ld(1'b1, 3'b100, 12'h013);
    #1;
    check("t2_stall", ld_stall, 1'b1);
    check("t2_we", mem_we, 1'b1);
    check("t2_addr", mem_addr, 12'h010);
    cycle();
    check("t2_unstall", ld_stall, 1'b0);
    check("t2_rdata", mem_read(int'(mem_addr), mem_funct3), 32'h000000DE);
    cycle();
    set_ld(1'b0, 3'b000, 0);

    // 3: fill while a non-overlapping load holds the port, then drain in order.
    set_ld(1'b1, 3'b010, 12'h200);
    for (int i = 0; i < DEPTH; i++) begin
      set_st(1'b1, 3'b010, 12'h040 + 4 * i, $urandom);
      cycle();
    end
    set_st(1'b1, 3'b010, 12'h050, 32'h1234);
    #1;
    check("t3_full_ready", st_ready, 1'b0);
    check("t3_count", count, DEPTH);
    check("t3_no_drain", mem_we, 1'b0);
    cycle();
    set_st(1'b0, 3'b000, 0, 32'h0); set_ld(1'b0, 3'b000, 0);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("t3_order", mem_addr, 12'h040 + 4 * i);
      cycle();
    end
    check("t3_empty", empty, 1'b1);

    // 4: fence with two pending entries.
    set_ld(1'b1, 3'b010, 12'h200);
    set_st(1'b1, 3'b010, 12'h060, 32'hA5A5A5A5); cycle();
    set_st(1'b1, 3'b001, 12'h066, 32'h00005A5A); cycle();
    set_st(1'b0, 3'b000, 0, 32'h0); set_ld(1'b0, 3'b000, 0); drain_req = 1'b1;
    #1;
    check("t4_busy0", fence_busy, 1'b1);
    cycle();
    check("t4_busy1", fence_busy, 1'b1);
    check("t4_ready_blocked", st_ready, 1'b0);
    cycle();
    check("t4_busy_done", fence_busy, 1'b0);
    check("t4_ready_back", st_ready, 1'b1);
    cycle();
    drain_req = 1'b0;

    // 5: halfword forwarding versus partial overlap.
    set_ld(1'b1, 3'b010, 12'h200);
    set_st(1'b1, 3'b001, 12'h020, 32'h00008001); cycle();
    set_st(1'b0, 3'b000, 0, 32'h0); set_ld(1'b1, 3'b101, 12'h021);
    #1;
    check("t5_lhu_stall", ld_stall, 1'b1);
    cycle();
    set_ld(1'b1, 3'b010, 12'h200);
    set_st(1'b1, 3'b001, 12'h020, 32'h00008001); cycle();
    set_st(1'b0, 3'b000, 0, 32'h0); set_ld(1'b1, 3'b001, 12'h020);
    #1;
`ifdef STORE_FWD_EN
    check("t5_fwd_valid", fwd_valid, 1'b1);
    check("t5_fwd_data", fwd_data, 32'hFFFF8001);
    check("t5_lh_nostall", ld_stall, 1'b0);
`else
    check("t5_fwd_valid", fwd_valid, 1'b0);
    check("t5_lh_stall", ld_stall, 1'b1);
`endif
    cycle();
    set_ld(1'b0, 3'b000, 0);
    cycle();

    // 6: unsupported size is dropped; push and pop together keep count.
    set_ld(1'b1, 3'b010, 12'h200);
    set_st(1'b1, 3'b010, 12'h080, 32'h11111111); cycle();
    set_st(1'b1, 3'b010, 12'h084, 32'h22222222); cycle();
    set_st(1'b1, 3'b011, 12'h088, 32'h33333333);
    #1;
    check("t6_bad_ready", st_ready, 1'b1);
    cycle();
    check("t6_bad_count", count, 2);
    set_ld(1'b0, 3'b000, 0); set_st(1'b1, 3'b010, 12'h08C, 32'h44444444);
    #1;
    check("t6_we", mem_we, 1'b1);
    cycle();
    check("t6_pushpop_count", count, 2);
    set_st(1'b0, 3'b000, 0, 32'h0);
    cycle(); cycle();

    // Random traffic on a small address window to provoke overlaps.
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      set_st($urandom_range(0, 1), (r < 3) ? 3'b000 : (r < 6) ? 3'b001 : (r < 9) ? 3'b010 : 3'b011,
             $urandom_range(0, 63), $urandom);
      set_ld($urandom_range(0, 9) < 4, lf3[$urandom_range(0, 4)], $urandom_range(0, 63));
      drain_req = ($urandom_range(0, 19) == 0);
      cycle();
    end

    // Quiesce with a bounded drain.
    set_st(1'b0, 3'b000, 0, 32'h0); set_ld(1'b0, 3'b000, 0); drain_req = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    check("final_empty", empty, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
